// File: rtl/vpu_pkg.sv
`default_nettype none
// ============================================================================
// Module      : VPU_PKG
// Description : Shared VPU constants, destination-port state encoding and
//               operand address decode helpers.
// Revision    : 1.0 - initial release
// ============================================================================
package VPU_PKG;

  // Operand SRAM geometry: 4 banks of 16 rows, each row one DIM_SIZE vector.
  localparam int SRAM_BANK_CNT_LG2   = 2;
  localparam int SRAM_BANK_DEPTH_LG2 = 4;
  localparam int OPERAND_ADDR_WIDTH  = SRAM_BANK_CNT_LG2 + SRAM_BANK_DEPTH_LG2;
  localparam int DIM_SIZE            = 64;

  // Destination port controller states.
  typedef enum logic [2:0] {
    S_IDLE  = 3'd0,
    S_FETCH = 3'd1,
    S_LOAD  = 3'd2,
    S_REQ   = 3'd3,
    S_DONE  = 3'd4
  } dst_state_t;

  // Bank index lives in the upper bits of an operand address.
  function automatic logic [SRAM_BANK_CNT_LG2-1:0] get_bank_id(
    input logic [OPERAND_ADDR_WIDTH-1:0] addr
  );
    return SRAM_BANK_CNT_LG2'(addr >> SRAM_BANK_DEPTH_LG2);
  endfunction

  // Row within the bank lives in the lower bits of an operand address.
  function automatic logic [SRAM_BANK_DEPTH_LG2-1:0] get_raddr(
    input logic [OPERAND_ADDR_WIDTH-1:0] addr
  );
    return SRAM_BANK_DEPTH_LG2'(addr);
  endfunction

endpackage
`default_nettype wire

// File: rtl/sram_port_if.sv
`default_nettype none
// ============================================================================
// Module      : SRAM_R_PORT_IF / SRAM_W_PORT_IF
// Description : Read and write port bundles between VPU port controllers
//               and the banked operand SRAM arbiters.
// Revision    : 1.0 - initial release
// ============================================================================
interface SRAM_R_PORT_IF;
  import VPU_PKG::*;

  logic                           req;
  logic [SRAM_BANK_CNT_LG2-1:0]   rid;
  logic [SRAM_BANK_DEPTH_LG2-1:0] addr;
  logic                           ack;
  logic [DIM_SIZE-1:0]            rdata;

  modport host   (output req, rid, addr, input  ack, rdata);
  modport device (input  req, rid, addr, output ack, rdata);
endinterface

interface SRAM_W_PORT_IF;
  import VPU_PKG::*;

  logic                           req;
  logic [SRAM_BANK_CNT_LG2-1:0]   wid;
  logic [SRAM_BANK_DEPTH_LG2-1:0] addr;
  logic                           web;    // active-low write enable
  logic                           wlast;
  logic [DIM_SIZE-1:0]            wdata;
  logic                           ack;

  modport host   (output req, wid, addr, web, wlast, wdata, input  ack);
  modport device (input  req, wid, addr, web, wlast, wdata, output ack);
endinterface
`default_nettype wire

// File: rtl/vpu_dst_port_controller.sv
`default_nettype none
// ============================================================================
// Module      : vpu_dst_port_controller
// Description : Drains result vectors from the result queue and writes 1 to
//               MAX_BEATS consecutive rows of one operand SRAM bank, then
//               signals completion to the VPU controller.
//               Optional feature macro: VPU_DST_STALL_CNT_EN (stall counter).
// Revision    : 1.0 - initial release
// ============================================================================
module vpu_dst_port_controller
  import VPU_PKG::*;
#(
  parameter  int MAX_BEATS = 4,
  localparam int BEAT_LG2  = (MAX_BEATS > 2) ? $clog2(MAX_BEATS) : 1
) (
  input  logic                          clk,
  input  logic                          rst,
  // request from the VPU controller
  input  logic                          valid_i,
  output logic                          ready_o,
  input  logic                          wvalid_i,
  input  logic [OPERAND_ADDR_WIDTH-1:0] waddr_i,
  input  logic [BEAT_LG2-1:0]           wlen_i,
  input  logic                          reset_cmd_i,
  output logic                          done_o,
  // result queue
  input  logic [DIM_SIZE-1:0]           rdata_i,
  output logic                          rden_o,
  input  logic                          rdempty_i,
  // SRAM write port
  SRAM_W_PORT_IF.host                   sram_wr_if,
  output logic [31:0]                   stall_cnt_o
);

  dst_state_t                     state;
  dst_state_t                     next_state;
  logic [SRAM_BANK_CNT_LG2-1:0]   bank;
  logic [SRAM_BANK_DEPTH_LG2-1:0] row;
  logic [BEAT_LG2-1:0]            remaining;

  logic accept;
  logic accept_write;
  logic last_beat;
  logic handshake;

  assign accept       = (state == S_IDLE) && valid_i;
  assign accept_write = accept && wvalid_i;
  assign last_beat    = (remaining == '0);
  assign handshake    = (state == S_REQ) && sram_wr_if.req && sram_wr_if.ack;

  // Status strobes decode straight from the state register.
  assign ready_o = (state == S_IDLE);
  assign done_o  = (state == S_DONE);
  // The pop happens only in FETCH, so a beat's data is never pulled before
  // the previous beat's handshake has completed.
  assign rden_o  = (state == S_FETCH) && !rdempty_i;

  // Next-state decode.
  always_comb begin
    next_state = state;
    case (state)
      S_IDLE: begin
        if (valid_i) next_state = wvalid_i ? S_FETCH : S_DONE;
      end
      S_FETCH: begin
        if (!rdempty_i) next_state = S_LOAD;
      end
      S_LOAD: begin
        next_state = S_REQ;
      end
      S_REQ: begin
        if (handshake) next_state = last_beat ? S_DONE : S_FETCH;
      end
      S_DONE: begin
        if (reset_cmd_i) next_state = S_IDLE;
      end
      default: begin
        next_state = S_IDLE;
      end
    endcase
  end

  // State register.
  always_ff @(posedge clk) begin
    if (rst) state <= S_IDLE;
    else     state <= next_state;
  end

  // Burst bookkeeping and registered SRAM write-port outputs.
  always_ff @(posedge clk) begin
    if (rst) begin
      bank             <= '0;
      row              <= '0;
      remaining        <= '0;
      sram_wr_if.req   <= 1'b0;
      sram_wr_if.wid   <= '0;
      sram_wr_if.addr  <= '0;
      sram_wr_if.web   <= 1'b1;
      sram_wr_if.wlast <= 1'b0;
      sram_wr_if.wdata <= '0;
    end else begin
      if (accept_write) begin
        bank      <= get_bank_id(waddr_i);
        row       <= get_raddr(waddr_i);
        remaining <= wlen_i;
      end
      // Queue data lands the cycle after the pop; launch the write with it.
      if (state == S_LOAD) begin
        sram_wr_if.wdata <= rdata_i;
        sram_wr_if.req   <= 1'b1;
        sram_wr_if.web   <= 1'b0;
        sram_wr_if.wlast <= last_beat;
        sram_wr_if.wid   <= bank;
        sram_wr_if.addr  <= row;
      end
      // Return the bus to its idle values; wdata deliberately keeps the last
      // beat. The row counter wraps inside the same bank.
      if (handshake) begin
        sram_wr_if.req   <= 1'b0;
        sram_wr_if.web   <= 1'b1;
        sram_wr_if.wlast <= 1'b0;
        sram_wr_if.wid   <= '0;
        sram_wr_if.addr  <= '0;
        if (!last_beat) begin
          remaining <= remaining - BEAT_LG2'(1);
          row       <= row + SRAM_BANK_DEPTH_LG2'(1);
        end
      end
    end
  end

`ifdef VPU_DST_STALL_CNT_EN
  logic [31:0] stall_cnt;
  logic        stall_cycle;

  assign stall_cycle = ((state == S_FETCH) && rdempty_i) ||
                       ((state == S_REQ) && !sram_wr_if.ack);

  // Saturating stall counter, cleared whenever a new request is taken.
  always_ff @(posedge clk) begin
    if (rst) begin
      stall_cnt <= '0;
    end else if (accept) begin
      stall_cnt <= '0;
    end else if (stall_cycle && (stall_cnt != '1)) begin
      stall_cnt <= stall_cnt + 32'd1;
    end
  end

  assign stall_cnt_o = stall_cnt;
`else
  assign stall_cnt_o = '0;
`endif

endmodule
`default_nettype wire

// File: doc/vpu_dst_port_controller.md
# vpu_dst_port_controller

Write-side counterpart of the VPU source port controller. It drains result vectors from the result queue and writes them to the banked operand SRAM through one SRAM write port. Each accepted request writes 1 to MAX_BEATS consecutive rows of a single bank, then reports completion to the VPU controller. One instance sits per destination port, between the result FIFO and the SRAM write arbiter.

## Interface
- MAX_BEATS, 4: maximum rows written per request; power of two, at least 1. BEAT_LG2 = max(1, $clog2(MAX_BEATS)).
- clk  in  1  clock.
- rst  in  1  reset; synchronous, active-high.
- valid_i  in  1  request valid, from REQ_IF.dst.
- ready_o  out  1  request accept; high only in S_IDLE.
- wvalid_i  in  1  request carries a write. 0 means no-op completion.
- waddr_i  in  OPERAND_ADDR_WIDTH  start operand address. Bank = get_bank_id(waddr_i), row = get_raddr(waddr_i).
- wlen_i  in  BEAT_LG2  beats minus one.
- reset_cmd_i  in  1  from VPU_CONTROLLER; re-arms the block from S_DONE.
- done_o  out  1  high while in S_DONE.
- rdata_i  in  DIM_SIZE  result queue data; valid the cycle after rden_o.
- rden_o  out  1  result queue pop strobe.
- rdempty_i  in  1  result queue empty.
- sram_wr_if  SRAM_W_PORT_IF.host  carries:
  - outputs req, wid[SRAM_BANK_CNT_LG2], addr[SRAM_BANK_DEPTH_LG2], web (active-low), wlast, wdata[DIM_SIZE];
  - input ack.
- stall_cnt_o  out  32  stall counter (see Configuration).

## Operation
- States: S_IDLE, S_FETCH, S_LOAD, S_REQ, S_DONE.
- S_IDLE:
  - valid_i and wvalid_i: latch bank, row and remaining = wlen_i, then go to S_FETCH.
  - valid_i and !wvalid_i: go to S_DONE. No SRAM or queue activity.
- S_FETCH: when !rdempty_i, assert rden_o combinationally for exactly this cycle and go to S_LOAD. Otherwise hold, with no pop.
- S_LOAD: capture rdata_i into the wdata register. Next cycle: req=1, web=0, wlast=(remaining==0); go to S_REQ.
- S_REQ: hold req, wid, addr, web, wlast and wdata stable until req&&ack.
  - On handshake with remaining==0: deassert req, web=1, go to S_DONE.
  - On handshake with remaining!=0: remaining-1; row+1 modulo 2^SRAM_BANK_DEPTH_LG2 (wraps to row 0 of the same bank, wid unchanged); deassert req; go to S_FETCH.
- S_DONE: done_o=1. reset_cmd_i returns to S_IDLE. reset_cmd_i is ignored in every other state.
- Inactive SRAM bus values: req=0, wid=0, addr=0, web=1, wlast=0. wdata holds its last value.
- Exactly one queue pop per beat. Data is never popped ahead of the SRAM handshake of the previous beat.

## Timing
- Reset values: state S_IDLE, req=0, wid=0, addr=0, web=1, wlast=0, wdata=0, rden_o=0, done_o=0, ready_o=1, stall_cnt_o=0.
- All SRAM outputs are registered. rden_o, ready_o and done_o are decoded from state.
- Beat cost with a non-empty queue and ack in the first req cycle: FETCH, LOAD, REQ = 3 cycles. A 1-beat write issues req 2 cycles after acceptance. done_o rises 1 cycle after the final handshake.
- rst asserted in any state: next edge goes to reset values and drops req mid-handshake. Queue contents are untouched.
- valid_i while not in S_IDLE is not accepted, since ready_o=0.

## Configuration
- VPU_DST_STALL_CNT_EN defined: stall_cnt_o counts cycles in S_FETCH with rdempty_i=1 plus cycles in S_REQ with ack=0. It saturates at 2^32-1 and clears on rst or on request acceptance.
- Not defined: stall_cnt_o tied to 0 and no counter flops are built.

## Structure
- VPU_PKG holds:
  - dst_state_t enum;
  - existing constants OPERAND_ADDR_WIDTH, DIM_SIZE, SRAM_BANK_CNT_LG2 and SRAM_BANK_DEPTH_LG2;
  - existing functions get_bank_id and get_raddr, reused unchanged.
- SRAM_W_PORT_IF is declared alongside SRAM_R_PORT_IF.
- No sub-modules: one FSM and a datapath register block.

## Test plan
- Single beat: waddr maps to bank 2 row 5, wlen=0, queue holds 0xA5…, ack immediate. Require 1 pop, one req with wid=2, addr=5, wlast=1, wdata=0xA5…, and done_o 1 cycle after the handshake.
- Burst wrapping: wlen=3 starting at the last row of bank 1. Require addresses last, 0, 1, 2 in bank 1, wlast on the 4th beat only, and 4 pops in order.
- Empty queue: rdempty_i=1 for 10 cycles in S_FETCH. Require no rden_o and no req; the beat proceeds after rdempty_i falls. With the macro, stall_cnt_o=10.
- Ack backpressure: ack held low for 7 cycles. Require req, addr and wdata stable throughout and no extra pop.
- No-op: valid_i=1 with wvalid_i=0. Require S_DONE next cycle with zero req and zero rden_o. reset_cmd_i then gives ready_o=1.
- Mid-burst reset: rst during the S_REQ of beat 2. Require reset values next cycle and ready_o=1. A new request afterwards starts fresh with remaining=wlen_i.
